// File: rtl/neander_x_pkg.sv
// Shared Neander definitions: datapath width, divider FSM states and the ALU
// opcodes that make the control unit pulse the divider's start.
package neander_x_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned DIV_STEPS = DATA_W;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_DONE
    } div_state_t;

    localparam logic [3:0] ALU_DIV = 4'b1010;
    localparam logic [3:0] ALU_MOD = 4'b1011;

endpackage

// File: rtl/neander_seq_divider_if.sv
// Handshake and result bus between the control unit/ALU (master) and the
// sequential divider (slave).
interface neander_seq_divider_if
    import neander_x_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) ();

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] div_quotient;
    logic [WIDTH-1:0] div_remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, div_quotient, div_remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, div_quotient, div_remainder, div_by_zero
    );

endinterface

// File: rtl/neander_seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock, for ALU DIV/MOD.
// Define NEANDER_DIV_FAST_ZERO_EN to finish a divide-by-zero on the accepting edge.
module neander_seq_divider
    import neander_x_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    neander_seq_divider_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    div_state_t       state;
    div_state_t       state_next;
    logic             busy_q;
    logic             done_q;
    logic             busy_next;
    logic             done_next;

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] r_reg;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] rem_reg;
    logic             dbz_reg;

    logic             accept;
    logic             last_step;
    logic             zero_skip;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] r_step;

    assign accept    = bus.start && (state != DIV_RUN);
    assign last_step = (state == DIV_RUN) && (cnt == CNT_W'(1));

`ifdef NEANDER_DIV_FAST_ZERO_EN
    assign zero_skip = accept && (bus.divisor == '0);
`else
    assign zero_skip = 1'b0;
`endif

    // One restoring step; the (WIDTH+1)-bit partial remainder only exists after the shift
    always_comb begin
        r_shift = {r_reg, q_reg[WIDTH-1]};
        trial   = r_shift - {1'b0, d_reg};
        fits    = ~trial[WIDTH];
        r_step  = fits ? trial[WIDTH-1:0] : r_shift[WIDTH-1:0];
        q_step  = {q_reg[WIDTH-2:0], fits};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= DIV_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            busy_q <= busy_next;
            done_q <= done_next;
        end
    end

    // DONE accepts a new start exactly like IDLE so back-to-back ops need no bubble
    always_comb begin
        state_next = state;
        unique case (state)
            DIV_IDLE: begin
                if (accept) state_next = zero_skip ? DIV_DONE : DIV_RUN;
            end
            DIV_RUN: begin
                if (last_step) state_next = DIV_DONE;
            end
            DIV_DONE: begin
                if (accept) state_next = zero_skip ? DIV_DONE : DIV_RUN;
                else        state_next = DIV_IDLE;
            end
            default: state_next = DIV_IDLE;
        endcase
    end

    always_comb begin
        busy_next = (state_next == DIV_RUN);
        done_next = (state_next == DIV_DONE);
    end

    // Working registers and the result registers that hold until the next completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg   <= '0;
            d_reg   <= '0;
            r_reg   <= '0;
            cnt     <= '0;
            quo_reg <= '0;
            rem_reg <= '0;
            dbz_reg <= 1'b0;
        end else begin
            if (accept) begin
                q_reg <= bus.dividend;
                d_reg <= bus.divisor;
                r_reg <= '0;
                cnt   <= CNT_W'(WIDTH);
            end else if (state == DIV_RUN) begin
                q_reg <= q_step;
                r_reg <= r_step;
                cnt   <= cnt - CNT_W'(1);
            end

            if (last_step) begin
                quo_reg <= q_step;
                rem_reg <= r_step;
                dbz_reg <= (d_reg == '0);
            end else if (zero_skip) begin
                quo_reg <= '1;
                rem_reg <= bus.dividend;
                dbz_reg <= 1'b1;
            end
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.div_quotient  = quo_reg;
    assign bus.div_remainder = rem_reg;
    assign bus.div_by_zero   = dbz_reg;

endmodule

// File: tb/tb_neander_seq_divider.sv
// Scoreboard bench for neander_seq_divider: directed divisions queue their
// expected results and completion cycle; a negedge monitor checks them.
module tb_neander_seq_divider;
    import neander_x_pkg::*;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
        int         due;
    } exp_t;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
    } snap_t;

`ifdef NEANDER_DIV_FAST_ZERO_EN
    localparam int ZLAT = 0;
`else
    localparam int ZLAT = 8;
`endif

    logic  clk = 1'b0;
    logic  rst_n;
    exp_t  sb[$];
    snap_t exp_snap;
    int    snap_seq  = 0;
    int    snap_seen = 0;
    int    cyc   = 0;
    int    total = 0;
    int    bad   = 0;

    neander_seq_divider_if bus ();

    neander_seq_divider dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: one-shot snapshots, busy/done exclusivity, scoreboard pops and timeouts
    initial begin : monitor
        exp_t  e;
        snap_t got;
        forever begin
            @(negedge clk);
            got.busy = bus.busy;
            got.done = bus.done;
            got.q    = bus.div_quotient;
            got.r    = bus.div_remainder;
            got.z    = bus.div_by_zero;
            if (snap_seq != snap_seen) begin
                total++;
                if (got !== exp_snap) begin
                    bad++;
                    $display("FAIL snap%0d cyc=%0d: got busy=%b done=%b q=%h r=%h z=%b, want busy=%b done=%b q=%h r=%h z=%b",
                             snap_seq, cyc, got.busy, got.done, got.q, got.r, got.z,
                             exp_snap.busy, exp_snap.done, exp_snap.q, exp_snap.r, exp_snap.z);
                end
                snap_seen = snap_seq;
            end
            total++;
            if (got.busy && got.done) begin
                bad++;
                $display("FAIL busy_done_overlap cyc=%0d: both high, want at most one", cyc);
            end
            if (got.done === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done cyc=%0d: got q=%h r=%h z=%b, want no done", cyc, got.q, got.r, got.z);
                end else begin
                    e = sb.pop_front();
                    total++;
                    if (got.q !== e.q || got.r !== e.r || got.z !== e.z) begin
                        bad++;
                        $display("FAIL result cyc=%0d: got q=%h r=%h z=%b, want q=%h r=%h z=%b",
                                 cyc, got.q, got.r, got.z, e.q, e.r, e.z);
                    end
                    total++;
                    if (cyc != e.due) begin
                        bad++;
                        $display("FAIL latency: done at cyc=%0d, want cyc=%0d", cyc, e.due);
                    end
                end
            end else if (sb.size() > 0 && cyc > sb[0].due) begin
                e = sb.pop_front();
                total++;
                bad++;
                $display("FAIL timeout cyc=%0d: no done, want q=%h r=%h z=%b by cyc=%0d", cyc, e.q, e.r, e.z, e.due);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap(input logic b, input logic d, input logic [7:0] q,
                        input logic [7:0] r, input logic z);
        exp_snap = '{busy: b, done: d, q: q, r: r, z: z};
        snap_seq++;
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq,
                         input logic [7:0] er, input logic ez, input int lat);
        exp_t e;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        e.q   = eq;
        e.r   = er;
        e.z   = ez;
        e.due = cyc + 1 + lat;
        sb.push_back(e);
        tick();
        bus.start    = 1'b0;
        bus.dividend = 8'hA5;
        bus.divisor  = 8'h5A;
    endtask

    task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq,
                       input logic [7:0] er, input logic ez, input int lat);
        issue(a, b, eq, er, ez, lat);
        repeat (10) tick();
    endtask

    initial begin : stim
        logic [7:0] ta [4];
        logic [7:0] tb [4];
        logic [7:0] tq [4];
        logic [7:0] tr [4];
        ta = '{8'd255, 8'd3,   8'd0, 8'd200};
        tb = '{8'd1,   8'd200, 8'd9, 8'd200};
        tq = '{8'hFF,  8'h00,  8'h00, 8'h01};
        tr = '{8'h00,  8'h03,  8'h00, 8'h00};

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        snap(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick();

        // 100/7 with per-cycle busy window, done pulse and hold afterwards
        issue(8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 8);
        for (int i = 0; i < 8; i++) begin
            snap(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
            tick();
        end
        snap(1'b0, 1'b1, 8'h0E, 8'h02, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            snap(1'b0, 1'b0, 8'h0E, 8'h02, 1'b0);
            tick();
        end

        for (int i = 0; i < 4; i++) run(ta[i], tb[i], tq[i], tr[i], 1'b0, 8);

        run(8'd5, 8'd0, 8'hFF, 8'h05, 1'b1, ZLAT);
        run(8'd10, 8'd3, 8'h03, 8'h01, 1'b0, 8);

        // A second start while busy must be dropped
        issue(8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 8);
        repeat (2) tick();
        bus.start    = 1'b1;
        bus.dividend = 8'd50;
        bus.divisor  = 8'd5;
        tick();
        bus.start = 1'b0;
        repeat (12) tick();
        snap(1'b0, 1'b0, 8'h0E, 8'h02, 1'b0);
        tick();

        // Start presented during the DONE cycle of the previous op
        issue(8'd60, 8'd7, 8'h08, 8'h04, 1'b0, 8);
        repeat (8) tick();
        issue(8'd81, 8'd9, 8'h09, 8'h00, 1'b0, 8);
        repeat (10) tick();

        // Asynchronous reset in the middle of a run, then a fresh division
        bus.start    = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor  = 8'd7;
        tick();
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 snap(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (12) tick();
        snap(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        run(8'd17, 8'd4, 8'h04, 8'h01, 1'b0, 8);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/neander_seq_divider.md
Name: neander_seq_divider

Overview:
- Area-efficient 8-bit unsigned restoring divider; the upstream stage for the ALU's DIV/MOD opcodes (1010/1011).
- The control unit pulses start with AC (dividend) and memory operand (divisor).
- After completion, the ALU consumes div_quotient, div_remainder and div_by_zero combinationally, then routes them to AC, Y and the carry flag.
- One quotient bit per clock; replaces an array divider.

Parameters:
- WIDTH, 8, operand and result width. Only 8 is verified; the counter is sized $clog2(WIDTH)+1.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request a division; sampled on rising edge; accepted only when busy=0
- dividend  input  WIDTH  numerator (a); sampled on the accepting edge only
- divisor  input  WIDTH  denominator (b); sampled on the accepting edge only
- busy  output  1  high while a division is running
- done  output  1  one-cycle completion pulse
- div_quotient  output  WIDTH  registered quotient
- div_remainder  output  WIDTH  registered remainder
- div_by_zero  output  1  registered flag: last accepted divisor was 0

Behaviour:
- Reset (async assert, any state):
  - state=IDLE; busy=0, done=0; div_quotient=0, div_remainder=0, div_by_zero=0; working registers=0.
  - Reset mid-operation discards the division; no done is produced.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 at edge N latches dividend into Q, divisor into D, clears partial remainder R (WIDTH+1 bits), sets cnt=WIDTH, goes to RUN.
  - RUN: each edge executes one restoring step:
    - shift {R,Q} left by 1;
    - trial = R - {0,D};
    - if trial non-negative: R=trial, Q[0]=1; else Q[0]=0;
    - cnt decrements.
  - RUN exit: the edge where cnt reaches 0 (edge N+8) goes to DONE and copies Q→div_quotient, R[WIDTH-1:0]→div_remainder, (D==0)→div_by_zero.
  - DONE: done=1 for exactly one cycle; next edge goes to IDLE. A start sampled in DONE is accepted identically to IDLE (back-to-back operation, no bubble).
- busy=1 exactly in RUN; done=1 exactly in DONE; never both.
- Latency: start edge N → done high in the cycle after edge N+8 (8 step cycles + 1 done cycle).
- Start while busy=1 is ignored; the operand inputs are don't-care outside the accepting edge.
- Result outputs hold their last values from one completion until the next completion. They are stable during RUN, so the ALU may read them at any time after done.
- Divide by zero, no special path: the restoring algorithm naturally yields quotient=all ones (0xFF) and remainder=dividend, with div_by_zero=1, after the normal latency.
- Arithmetic is unsigned only. Any remainder is < divisor when divisor != 0.

Optional Feature:
- Macro NEANDER_DIV_FAST_ZERO_EN.
- Defined: a start with divisor==0 skips RUN and goes IDLE→DONE on the accepting edge. Outputs are div_quotient=0xFF, div_remainder=dividend, div_by_zero=1, with done one cycle later (latency 1).
- Undefined: divide-by-zero takes the full 8-step path. Result values are identical in both builds; only latency differs.

Decomposition:
- Shared package neander_x_pkg:
  - DATA_W=8, DIV_STEPS=DATA_W;
  - typedef enum logic [1:0] div_state_t {DIV_IDLE, DIV_RUN, DIV_DONE};
  - ALU opcode constants ALU_DIV=4'b1010 and ALU_MOD=4'b1011, so the control unit uses one source for deciding when to pulse start.
- No sub-module: the single restoring step is inline combinational logic.

Test Plan:
- 100/7: start pulse → busy=1 for 8 cycles, done pulse in the cycle after edge N+8; quotient=0x0E, remainder=0x02, div_by_zero=0; outputs unchanged for 5 idle cycles afterwards.
- Boundaries:
  - 255/1 → 0xFF r 0x00;
  - 3/200 → 0x00 r 0x03;
  - 0/9 → 0x00 r 0x00;
  - 200/200 → 0x01 r 0x00.
- 5/0 → quotient=0xFF, remainder=0x05, div_by_zero=1. Done at edge N+9 (macro undefined) or N+1 (macro defined). The next 10/3 clears the flag: 0x03 r 0x01.
- Start re-pulsed with 50/5 while busy → ignored; original 100/7 result returned; exactly one done.
- Back-to-back: start held during the DONE cycle with 81/9 → accepted without an idle bubble, then 0x09 r 0x00 eight cycles later.
- rst_n asserted at step 4 of a run → busy, done and all outputs 0 immediately (asynchronous). No done after release; a fresh 17/4 → 0x04 r 0x01.
